// File: rtl/spi_cmd_master.sv
// SPI mode-0 initiator for the TRS-IO FPGA command protocol.
// Sends cmd + 0..4 param bytes, with an optional 9-bit response phase.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start             request strobe, taken only in IDLE outside done
//   cmd[7:0]          command byte, sent first, MSB first
//   params[31:0]      param bytes, [7:0] sent first
//   n_params[2:0]     param byte count, clamped to 4
//   resp_en           append 9-bit response phase
//   busy, done        transaction in progress / 1-cycle end pulse
//   resp[7:0]         response byte, updated with done when resp_en
//   SCK, MOSI, CS     SPI outputs (SCK idles low, CS active low)
//   MISO              asynchronous SPI input, double-flopped
module spi_cmd_master #(
    parameter int CLK_DIV  = 8,
    parameter int CS_SETUP = 8,
    parameter int CS_GAP   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic [31:0] params,
    input  logic [2:0]  n_params,
    input  logic        resp_en,
    output logic        busy,
    output logic        done,
    output logic [7:0]  resp,
    output logic        SCK,
    output logic        MOSI,
    output logic        CS,
    input  logic        MISO
);

    localparam int MAXC =
        (CLK_DIV > CS_SETUP)
            ? ((CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP)
            : ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP);
    localparam int CW = $clog2(MAXC) + 1;

    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        HOLD,
        GAP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [5:0]    bit_cnt;
    logic [5:0]    total;
    logic [39:0]   tx;
    logic [7:0]    rx;
    logic          miso_s1;
    logic          miso_s2;
    logic          resp_en_q;

    logic [2:0]    n_c;
    logic [5:0]    tot_in;
    logic [5:0]    bit_nx;
    logic [7:0]    p0, p1, p2, p3;

    assign n_c    = (n_params > 3'd4) ? 3'd4 : n_params;
    assign tot_in = 6'd8 + {n_c, 3'b000}
                  + (resp_en ? 6'd9 : 6'd0);
    assign bit_nx = bit_cnt + 6'd1;

    // Unsent param bytes load as zero, so the shifter
    // naturally drives MOSI=0 through the response phase.
    assign p0 = (n_c >= 3'd1) ? params[7:0]   : 8'h00;
    assign p1 = (n_c >= 3'd2) ? params[15:8]  : 8'h00;
    assign p2 = (n_c >= 3'd3) ? params[23:16] : 8'h00;
    assign p3 = (n_c >= 3'd4) ? params[31:24] : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            total     <= '0;
            tx        <= '0;
            rx        <= '0;
            miso_s1   <= 1'b0;
            miso_s2   <= 1'b0;
            resp_en_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            resp      <= 8'h00;
            SCK       <= 1'b0;
            MOSI      <= 1'b0;
            CS        <= 1'b1;
        end else begin
            miso_s1 <= MISO;
            miso_s2 <= miso_s1;
            done    <= 1'b0;
            cnt     <= cnt + CW'(1);
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    // done=1 marks the cycle right after GAP;
                    // a start there belongs to the old request.
                    if (start && !done) begin
                        state     <= SETUP;
                        busy      <= 1'b1;
                        CS        <= 1'b0;
                        MOSI      <= cmd[7];
                        tx        <= {cmd[6:0], p0, p1, p2, p3, 1'b0};
                        total     <= tot_in;
                        bit_cnt   <= '0;
                        resp_en_q <= resp_en;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        state <= LOW;
                        cnt   <= '0;
                    end
                end
                LOW: begin
                    if (cnt == DIV_LAST) begin
                        // Every bit is sampled; only the last
                        // eight (response samples 2..9) survive.
                        rx    <= {rx[6:0], miso_s2};
                        SCK   <= 1'b1;
                        state <= HIGH;
                        cnt   <= '0;
                    end
                end
                HIGH: begin
                    if (cnt == DIV_LAST) begin
                        SCK     <= 1'b0;
                        cnt     <= '0;
                        bit_cnt <= bit_nx;
                        if (bit_nx == total) begin
                            state <= HOLD;
                            MOSI  <= 1'b0;
                        end else begin
                            state <= LOW;
                            MOSI  <= tx[39];
                            tx    <= {tx[38:0], 1'b0};
                        end
                    end
                end
                HOLD: begin
                    if (cnt == DIV_LAST) begin
                        CS    <= 1'b1;
                        state <= GAP;
                        cnt   <= '0;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (resp_en_q) begin
                            resp <= rx;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
